lcd_cmd_arbiter: RTL and testbench

LCD_CMD_ARBITER -- requirements
Module: lcd_cmd_arbiter

---
 rtl/lcd_cmd_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_lcd_cmd_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_arbiter.sv
// lcd_cmd_arbiter: round-robin arbiter between two byte requesters feeding one
// LCD write engine, with a fixed settle delay after each completed write.
// Optional feature macro: LCD_ARB_TIMEOUT_EN (iDone timeout with sticky ERR).
module lcd_cmd_arbiter #(
    parameter int unsigned DLY_CYCLES = 262142,
    parameter int unsigned TO_CYCLES  = 1024
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic       RS0,
    input  logic       RS1,
    input  logic [7:0] DATA0,
    input  logic [7:0] DATA1,
    output logic       ACK0,
    output logic       ACK1,
    output logic [7:0] oDATA,
    output logic       oRS,
    output logic       oStart,
    input  logic       iDone,
    output logic       BUSY,
    output logic       ERR
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DELAY = 2'd3;

    // Delay counter only ever holds 0..DLY_CYCLES-1, so no wrap is possible.
    localparam int unsigned      DLY_W    = (DLY_CYCLES > 1) ? $clog2(DLY_CYCLES) : 1;
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DLY_CYCLES - 1);

    logic [1:0]       state_q,   state_d;
    logic             start_q,   start_d;
    logic [7:0]       data_q,    data_d;
    logic             rs_q,      rs_d;
    logic             owner_q,   owner_d;
    logic             rr_q,      rr_d;
    logic             ack0_q,    ack0_d;
    logic             ack1_q,    ack1_d;
    logic             busy_q,    busy_d;
    logic [DLY_W-1:0] dly_cnt_q, dly_cnt_d;

    logic             elig0_c;
    logic             elig1_c;
    logic             grant1_c;

`ifdef LCD_ARB_TIMEOUT_EN
    localparam int unsigned     TO_W    = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q,    err_d;
`endif

    // A requester whose ACK is showing this cycle is not eligible again yet.
    assign elig0_c  = REQ0 & ~ack0_q;
    assign elig1_c  = REQ1 & ~ack1_q;
    // rr_q=0 favours requester 0, rr_q=1 favours requester 1 on a tie.
    assign grant1_c = elig1_c & (~elig0_c | rr_q);

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        data_d    = data_q;
        rs_d      = rs_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        dly_cnt_d = dly_cnt_q;
`ifdef LCD_ARB_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (elig0_c || elig1_c) begin
                    state_d = S_START;
                    start_d = 1'b1;
                    owner_d = grant1_c;
                    data_d  = grant1_c ? DATA1 : DATA0;
                    rs_d    = grant1_c ? RS1 : RS0;
                end
            end
            S_START: begin
                // iDone is deliberately not looked at here.
                state_d  = S_WAIT;
`ifdef LCD_ARB_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                if (iDone) begin
                    state_d   = S_DELAY;
                    start_d   = 1'b0;
                    dly_cnt_d = '0;
                end
`ifdef LCD_ARB_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    state_d = S_IDLE;
                    start_d = 1'b0;
                    err_d   = 1'b1;
                    ack0_d  = ~owner_q;
                    ack1_d  = owner_q;
                    rr_d    = ~owner_q;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
`endif
            end
            S_DELAY: begin
                if (dly_cnt_q == DLY_LAST) begin
                    state_d = S_IDLE;
                    ack0_d  = ~owner_q;
                    ack1_d  = owner_q;
                    rr_d    = ~owner_q;
                end else begin
                    dly_cnt_d = dly_cnt_q + DLY_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            start_q   <= 1'b0;
            data_q    <= '0;
            rs_q      <= 1'b0;
            owner_q   <= 1'b0;
            rr_q      <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            busy_q    <= 1'b0;
            dly_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            data_q    <= data_d;
            rs_q      <= rs_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            busy_q    <= busy_d;
            dly_cnt_q <= dly_cnt_d;
        end
    end

`ifdef LCD_ARB_TIMEOUT_EN
    // Timeout counter and sticky error flag; ERR only clears on reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign ERR = err_q;
`else
    logic unused_to_c;
    assign unused_to_c = |TO_CYCLES;
    assign ERR         = 1'b0;
`endif

    assign ACK0   = ack0_q;
    assign ACK1   = ack1_q;
    assign oDATA  = data_q;
    assign oRS    = rs_q;
    assign oStart = start_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Bench for lcd_cmd_arbiter: directed scenarios plus random requesters and
// random resets, checked every cycle against a transaction-timing model.
module tb_lcd_cmd_arbiter;

    localparam int DLY = 4;
    localparam int TO  = 8;
`ifdef LCD_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk;
    logic       RST;
    logic       REQ0, REQ1, RS0, RS1;
    logic [7:0] DATA0, DATA1;
    logic       ACK0, ACK1;
    logic [7:0] oDATA;
    logic       oRS, oStart, iDone, BUSY, ERR;

    logic       req_v  [2];
    logic       rs_v   [2];
    logic [7:0] data_v [2];
    bit         drop_next [2];

    assign REQ0  = req_v[0];
    assign REQ1  = req_v[1];
    assign RS0   = rs_v[0];
    assign RS1   = rs_v[1];
    assign DATA0 = data_v[0];
    assign DATA1 = data_v[1];

    lcd_cmd_arbiter #(.DLY_CYCLES(DLY), .TO_CYCLES(TO)) dut (
        .CLK(clk), .RST(RST),
        .REQ0(REQ0), .REQ1(REQ1), .RS0(RS0), .RS1(RS1),
        .DATA0(DATA0), .DATA1(DATA1),
        .ACK0(ACK0), .ACK1(ACK1),
        .oDATA(oDATA), .oRS(oRS), .oStart(oStart), .iDone(iDone),
        .BUSY(BUSY), .ERR(ERR)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Engine model: holds iDone high from eng_L cycles after the oStart rise
    // until oStart falls.
    int eng_c    = -1;
    int eng_L    = 3;
    bit eng_en   = 1'b1;
    bit eng_rand = 1'b0;
    initial begin
        iDone = 1'b0;
        forever begin
            @(negedge clk);
            if (oStart !== 1'b1) begin
                iDone = 1'b0;
                eng_c = -1;
            end else begin
                eng_c++;
                if (eng_c == 0 && eng_rand) eng_L = $urandom_range(1, 5);
                if (eng_en && eng_c >= eng_L - 1) iDone = 1'b1;
            end
        end
    end

    // Reference model: event times derived from the grant edge.
    bit         model_ok = 1'b0;
    logic       m_busy, m_start, m_rs, m_ack0, m_ack1, m_err, m_owner, m_ptr;
    logic [7:0] m_data;
    int         m_grant_at, m_done_at;
    logic       m_e0, m_e1, m_g1;

    task automatic model_finish();
        m_ack0  = ~m_owner;
        m_ack1  = m_owner;
        m_ptr   = ~m_owner;
        m_busy  = 1'b0;
        m_start = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (RST === 1'b1) begin
                m_busy = 0; m_start = 0; m_rs = 0; m_ack0 = 0; m_ack1 = 0;
                m_err = 0; m_owner = 0; m_ptr = 0; m_data = 8'h00;
                m_grant_at = 0; m_done_at = -1;
                model_ok = 1'b1;
            end else if (model_ok) begin
                m_e0 = REQ0 && !m_ack0;
                m_e1 = REQ1 && !m_ack1;
                m_ack0 = 1'b0;
                m_ack1 = 1'b0;
                if (!m_busy) begin
                    if (m_e0 || m_e1) begin
                        m_g1       = m_e1 && (!m_e0 || m_ptr);
                        m_owner    = m_g1;
                        m_data     = m_g1 ? DATA1 : DATA0;
                        m_rs       = m_g1 ? RS1 : RS0;
                        m_busy     = 1'b1;
                        m_start    = 1'b1;
                        m_grant_at = cyc;
                        m_done_at  = -1;
                    end
                end else if (m_done_at < 0) begin
                    if (cyc >= m_grant_at + 2 && iDone === 1'b1) begin
                        m_done_at = cyc;
                        m_start   = 1'b0;
                    end else if (TO_EN && cyc == m_grant_at + 1 + TO) begin
                        m_err = 1'b1;
                        model_finish();
                    end
                end else if (cyc == m_done_at + DLY) begin
                    model_finish();
                end
            end
        end
    end

    // Per-cycle compare plus event monitor for the directed checks.
    int n_ack0 = 0, n_ack1 = 0, n_rise = 0;
    int busy_rise_cyc = 0, ack_cyc = 0, fall_cyc = 0, lowrun = 0;
    bit prev_start = 0, prev_busy = 0;
    int gaps[$];
    int ack_order[$];
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (model_ok) begin
                vectors++;
                if (ACK0 !== m_ack0 || ACK1 !== m_ack1 || oDATA !== m_data || oRS !== m_rs ||
                    oStart !== m_start || BUSY !== m_busy || ERR !== m_err) begin
                    miscompares++;
                    $display("FAIL cycle_compare cyc=%0d got ACK0=%b ACK1=%b oDATA=%h oRS=%b oStart=%b BUSY=%b ERR=%b, expected ACK0=%b ACK1=%b oDATA=%h oRS=%b oStart=%b BUSY=%b ERR=%b",
                             cyc, ACK0, ACK1, oDATA, oRS, oStart, BUSY, ERR,
                             m_ack0, m_ack1, m_data, m_rs, m_start, m_busy, m_err);
                end
            end
            if (ACK0 === 1'b1) begin n_ack0++; ack_cyc = cyc; ack_order.push_back(0); end
            if (ACK1 === 1'b1) begin n_ack1++; ack_cyc = cyc; ack_order.push_back(1); end
            if (oStart === 1'b1 && !prev_start) n_rise++;
            if (oStart !== 1'b1 && prev_start) fall_cyc = cyc;
            if (BUSY === 1'b1 && !prev_busy) begin busy_rise_cyc = cyc; gaps.push_back(lowrun); end
            lowrun     = (BUSY === 1'b1) ? 0 : lowrun + 1;
            prev_start = (oStart === 1'b1);
            prev_busy  = (BUSY === 1'b1);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ack(input int which, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if ((which == 0 && ACK0 === 1'b1) || (which == 1 && ACK1 === 1'b1)) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL wait_ack%0d: no ACK within %0d cycles, expected one", which, limit);
        end
    endtask

    task automatic wait_delay_state(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (BUSY === 1'b1 && oStart === 1'b0) found = 1'b1;
        end
        check(name, 32'(found), 32'd1);
    endtask

    int base0, base1, baser;
    bit found_b;

    initial begin
        RST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b0; rs_v[i] = 1'b0; data_v[i] = 8'h00; drop_next[i] = 1'b0;
        end
        tick(3);
        check("reset_outputs", 32'({ACK0, ACK1, oDATA, oRS, oStart, BUSY, ERR}), 32'd0);
        RST = 1'b0;

        // Single data write from requester 0.
        req_v[0] = 1'b1; rs_v[0] = 1'b1; data_v[0] = 8'h41;
        base0 = n_ack0; base1 = n_ack1; baser = n_rise;
        wait_ack(0, 50);
        req_v[0] = 1'b0;
        check("t033_oDATA", 32'(oDATA), 32'h41);
        check("t033_oRS", 32'(oRS), 32'd1);
        check("t033_grant_to_ack_edges", 32'(ack_cyc - busy_rise_cyc), 32'd7);
        tick(3);
        check("t033_ack0_count", 32'(n_ack0 - base0), 32'd1);
        check("t033_ack1_count", 32'(n_ack1 - base1), 32'd0);
        check("t033_ostart_rises", 32'(n_rise - baser), 32'd1);

        // Command write from requester 1 alone.
        req_v[1] = 1'b1; rs_v[1] = 1'b0; data_v[1] = 8'hC0;
        wait_ack(1, 50);
        req_v[1] = 1'b0;
        check("t035_oRS", 32'(oRS), 32'd0);
        check("t035_oDATA", 32'(oDATA), 32'hC0);
        check("t035_delay_cycles", 32'(ack_cyc - fall_cyc), 32'd4);
        tick(2);

        // Both requesters held from reset: alternate grants.
        RST = 1'b1;
        req_v[0] = 1'b1; data_v[0] = 8'h11; rs_v[0] = 1'b1;
        req_v[1] = 1'b1; data_v[1] = 8'h22; rs_v[1] = 1'b0;
        tick(2);
        RST = 1'b0;
        gaps.delete();
        ack_order.delete();
        for (int i = 0; i < 100 && ack_order.size() < 4; i++) @(negedge clk);
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        check("t034_four_acks", 32'(ack_order.size() >= 4), 32'd1);
        if (ack_order.size() >= 4) begin
            check("t034_order0", 32'(ack_order[0]), 32'd0);
            check("t034_order1", 32'(ack_order[1]), 32'd1);
            check("t034_order2", 32'(ack_order[2]), 32'd0);
            check("t034_order3", 32'(ack_order[3]), 32'd1);
        end
        if (gaps.size() >= 4) begin
            check("t034_gap1", 32'(gaps[1]), 32'd1);
            check("t034_gap2", 32'(gaps[2]), 32'd1);
            check("t034_gap3", 32'(gaps[3]), 32'd1);
        end else begin
            check("t034_grant_count", 32'(gaps.size()), 32'd4);
        end
        tick(2);

        // Reset during DELAY with REQ0 low: REQ1 is served, no ACK0 appears.
        req_v[0] = 1'b1; data_v[0] = 8'h5A; rs_v[0] = 1'b1;
        wait_delay_state("t036a_reached_delay");
        RST = 1'b1;
        req_v[0] = 1'b0;
        req_v[1] = 1'b1; data_v[1] = 8'hA5; rs_v[1] = 1'b0;
        base0 = n_ack0;
        tick(1);
        RST = 1'b0;
        check("t036a_reset_outputs", 32'({ACK0, ACK1, oDATA, oRS, oStart, BUSY, ERR}), 32'd0);
        wait_ack(1, 50);
        req_v[1] = 1'b0;
        check("t036a_no_ack0", 32'(n_ack0 - base0), 32'd0);
        tick(2);

        // Reset during DELAY with both high: pointer restarts at requester 0.
        req_v[0] = 1'b1; data_v[0] = 8'h3C;
        wait_delay_state("t036b_reached_delay");
        RST = 1'b1;
        req_v[1] = 1'b1; data_v[1] = 8'hC3;
        tick(1);
        RST = 1'b0;
        ack_order.delete();
        found_b = 1'b0;
        for (int i = 0; i < 50 && !found_b; i++) begin
            @(negedge clk);
            if (ACK0 === 1'b1 || ACK1 === 1'b1) found_b = 1'b1;
        end
        check("t036b_ack_seen", 32'(found_b), 32'd1);
        if (ack_order.size() > 0) check("t036b_first_owner", 32'(ack_order[0]), 32'd0);
        req_v[0] = 1'b0;
        wait_ack(1, 50);
        req_v[1] = 1'b0;
        tick(2);

        // Engine never completes.
        eng_en = 1'b0;
        req_v[0] = 1'b1; data_v[0] = 8'h77;
        base0 = n_ack0;
`ifdef LCD_ARB_TIMEOUT_EN
        wait_ack(0, 40);
        req_v[0] = 1'b0;
        check("t037_err", 32'(ERR), 32'd1);
        check("t037_ostart", 32'(oStart), 32'd0);
        check("t037_timeout_edges", 32'(ack_cyc - busy_rise_cyc), 32'd9);
`else
        tick(30);
        req_v[0] = 1'b0;
        check("t037_busy", 32'(BUSY), 32'd1);
        check("t037_ostart", 32'(oStart), 32'd1);
        check("t037_err", 32'(ERR), 32'd0);
        check("t037_no_ack", 32'(n_ack0 - base0), 32'd0);
`endif
        eng_en = 1'b1;
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        check("t037_err_after_reset", 32'(ERR), 32'd0);
        tick(1);

        // REQ0 withdrawn one cycle after its grant.
        req_v[0] = 1'b1; data_v[0] = 8'h99; rs_v[0] = 1'b0;
        found_b = 1'b0;
        for (int i = 0; i < 10 && !found_b; i++) begin
            @(negedge clk);
            if (BUSY === 1'b1) found_b = 1'b1;
        end
        check("t038_granted", 32'(found_b), 32'd1);
        req_v[0] = 1'b0;
        base0 = n_ack0;
        wait_ack(0, 50);
        check("t038_ack0_count", 32'(n_ack0 - base0), 32'd1);
        tick(2);

        // Random requesters, engine latency and occasional resets.
        eng_rand = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            RST = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 2; i++) begin
                if (req_v[i] && drop_next[i]) begin
                    req_v[i] = 1'b0;
                    drop_next[i] = 1'b0;
                end else if (req_v[i] && ((i == 0) ? ACK0 : ACK1) === 1'b1) begin
                    if ($urandom_range(0, 1) == 0) req_v[i] = 1'b0;
                    else drop_next[i] = 1'b1;
                end else if (req_v[i] && $urandom_range(0, 59) == 0) begin
                    req_v[i] = 1'b0;
                end else if (!req_v[i]) begin
                    data_v[i] = 8'($urandom);
                    rs_v[i]   = 1'($urandom);
                    if ($urandom_range(0, 2) == 0) req_v[i] = 1'b1;
                end
            end
        end
        RST = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not reach its end, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
